fft_stage_sequencer: RTL and testbench

//   Sequences an in-place radix-2 DIT FFT over a dual-port sample RAM with one shared, pipelined butterfly unit.
//   Per stage: issues one butterfly per cycle (RAM read addrs + twiddle index), tracks each through the

---
 rtl/fft_seq_if.sv | 31 +++
 rtl/fft_stage_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_seq_if.sv
// Control and RAM/butterfly-side signals of the FFT stage sequencer.
// master = CSR/control side (drives start/hold), slave = sequencer.
interface fft_seq_if #(
    parameter int LOG2N = 6
);
    logic             start;
    logic             hold;
    logic             busy;
    logic             done;
    logic [3:0]       stage;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic             bypass;
    logic             wb_en;
    logic [LOG2N-1:0] wb_addr_a;
    logic [LOG2N-1:0] wb_addr_b;

    modport master (
        output start, hold,
        input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx, bypass,
               wb_en, wb_addr_a, wb_addr_b
    );

    modport slave (
        input  start, hold,
        output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx, bypass,
               wb_en, wb_addr_a, wb_addr_b
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT sequencer: one butterfly issue per cycle, write-back tracking, stage drains.
// Define FFT_SEQ_BITREV_EN to add a bit-reversal permutation pass ahead of stage 0.
module fft_stage_sequencer #(
    parameter int LOG2N  = 6,
    parameter int BF_LAT = 3
) (
    input  logic      clk,
    input  logic      reset,
    fft_seq_if.slave  bus
);
    localparam int N      = 1 << LOG2N;
    localparam int HALFN  = N / 2;
    localparam int DCNT_W = $clog2(BF_LAT + 1);

    typedef enum logic [2:0] {S_IDLE, S_BREV, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    logic [LOG2N-1:0]    r_k;
    logic [3:0]          r_stage;
    logic [DCNT_W-1:0]   r_dcnt;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;

    logic                r_pv [BF_LAT];
    logic [LOG2N-1:0]    r_pa [BF_LAT];
    logic [LOG2N-1:0]    r_pb [BF_LAT];

    logic                w_rd_en;
    logic                w_adv;
    logic                w_last;
    logic                w_bypass;
    logic [LOG2N-1:0]    w_half;
    logic [LOG2N-1:0]    w_pos;
    logic [LOG2N-1:0]    w_grp;
    logic [LOG2N-1:0]    w_a;
    logic [LOG2N-1:0]    w_b;
    logic [LOG2N-2:0]    w_tw;
    logic [LOG2N-1:0]    w_wa;
    logic [LOG2N-1:0]    w_wb;

`ifdef FFT_SEQ_BITREV_EN
    logic [LOG2N-1:0]    w_rev;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        for (int j = 0; j < LOG2N; j++) bitrev[j] = v[LOG2N-1-j];
    endfunction
`endif

    always_comb begin
        w_rd_en  = 1'b0;
        w_adv    = 1'b0;
        w_last   = 1'b0;
        w_bypass = 1'b0;
        w_half   = '0;
        w_pos    = '0;
        w_grp    = '0;
        w_a      = '0;
        w_b      = '0;
        w_tw     = '0;
        w_wa     = '0;
        w_wb     = '0;
`ifdef FFT_SEQ_BITREV_EN
        w_rev    = bitrev(r_k);
`endif
        case (r_state)
            S_ISSUE: begin
                w_adv   = !bus.hold;
                w_rd_en = !bus.hold;
                w_last  = (r_k == LOG2N'(HALFN - 1));
                w_half  = LOG2N'(1) << r_stage;
                w_pos   = r_k & (w_half - 1'b1);
                w_grp   = r_k >> r_stage;
                w_a     = (w_grp << (r_stage + 4'd1)) | w_pos;
                w_b     = w_a + w_half;
                // pos < 2^s, so it fits the narrower twiddle index before scaling
                w_tw    = w_pos[LOG2N-2:0] << (LOG2N - 1 - r_stage);
                w_wa    = w_a;
                w_wb    = w_b;
            end
`ifdef FFT_SEQ_BITREV_EN
            S_BREV: begin
                w_adv    = !bus.hold;
                w_rd_en  = !bus.hold && (r_k < w_rev);
                w_bypass = w_rd_en;
                w_last   = (r_k == LOG2N'(N - 1));
                w_a      = r_k;
                w_b      = w_rev;
                w_wa     = w_rev;
                w_wb     = r_k;
            end
`endif
            default: ;
        endcase
        if (!w_rd_en) begin
            w_a  = '0;
            w_b  = '0;
            w_tw = '0;
            w_wa = '0;
            w_wb = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_stage <= '0;
            r_dcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_busy  <= 1'b1;
                    r_k     <= '0;
                    r_stage <= '0;
`ifdef FFT_SEQ_BITREV_EN
                    r_state <= S_BREV;
                    r_pass  <= 1'b1;
`else
                    r_state <= S_ISSUE;
`endif
                end
                S_BREV, S_ISSUE: if (w_adv) begin
                    r_k <= w_last ? '0 : r_k + 1'b1;
                    if (w_last) begin
                        r_state <= S_DRAIN;
                        r_dcnt  <= '0;
                    end
                end
                // Hold off the next stage until the last result has been written back
                S_DRAIN: begin
                    if (r_dcnt == DCNT_W'(BF_LAT - 1)) begin
                        if (r_pass) begin
                            r_pass  <= 1'b0;
                            r_state <= S_ISSUE;
                        end else if (r_stage == 4'(LOG2N - 1)) begin
                            r_state <= S_DONE;
                            r_stage <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_stage <= r_stage + 4'd1;
                            r_state <= S_ISSUE;
                        end
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write-back pipe: advances every cycle, hold only stops new entries
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BF_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pa[i] <= '0;
                r_pb[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_rd_en;
            r_pa[0] <= w_wa;
            r_pb[0] <= w_wb;
            for (int i = 1; i < BF_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pb[i] <= r_pb[i-1];
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.stage     = r_stage;
    assign bus.rd_en     = w_rd_en;
    assign bus.rd_addr_a = w_a;
    assign bus.rd_addr_b = w_b;
    assign bus.tw_idx    = w_tw;
    assign bus.bypass    = w_bypass;
    assign bus.wb_en     = r_pv[BF_LAT-1];
    assign bus.wb_addr_a = r_pa[BF_LAT-1];
    assign bus.wb_addr_b = r_pb[BF_LAT-1];
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer, LOG2N=3, BF_LAT=3, against hand-computed issue/write-back tables.
module tb_fft_stage_sequencer;
    localparam int LOG2N  = 3;
    localparam int BF_LAT = 3;
`ifdef FFT_SEQ_BITREV_EN
    localparam int OFS = 11;
    localparam int NSW = 2;
    int sw_rel [2] = '{2, 4};
    int sw_a   [2] = '{1, 3};
    int sw_b   [2] = '{4, 6};
`else
    localparam int OFS = 0;
    localparam int NSW = 0;
`endif

    typedef struct {
        int rel;
        int a;
        int b;
        int tw;
        int bp;
        int st;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fft_seq_if #(.LOG2N(LOG2N)) bus ();

    fft_stage_sequencer #(.LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int ea [12]         = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int eb [12]         = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int et [12]         = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};
    int rel_nohold [12] = '{1, 2, 3, 4,  8, 9, 10, 11,  15, 16, 17, 18};
    int rel_hold [12]   = '{1, 2, 3, 4,  8, 11, 12, 13,  17, 18, 19, 20};

    ev_t rdq [$];
    ev_t wbq [$];
    int  doneq [$];
    ev_t mon_e;
    int  cyc = 0;
    int  t0 = 0;
    int  n_chk = 0;
    int  n_fail = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (bus.rd_en) begin
            mon_e.rel = cyc - t0;
            mon_e.a   = int'(bus.rd_addr_a);
            mon_e.b   = int'(bus.rd_addr_b);
            mon_e.tw  = int'(bus.tw_idx);
            mon_e.bp  = int'(bus.bypass);
            mon_e.st  = int'(bus.stage);
            rdq.push_back(mon_e);
        end
        if (bus.wb_en) begin
            mon_e.rel = cyc - t0;
            mon_e.a   = int'(bus.wb_addr_a);
            mon_e.b   = int'(bus.wb_addr_b);
            mon_e.tw  = 0;
            mon_e.bp  = 0;
            mon_e.st  = 0;
            wbq.push_back(mon_e);
        end
        if (bus.done) begin
            doneq.push_back(cyc - t0);
            check_eq("busy_at_done", int'(bus.busy), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a transform, then steer hold/start/reset by the number of the upcoming cycle.
    task automatic run(input int hold_at, input int st_a, input int st_b, input int rst_at, input int ncyc);
        int rn;
        rdq.delete();
        wbq.delete();
        doneq.delete();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        t0 = cyc;
        for (int c = 0; c < ncyc; c++) begin
            rn = cyc - t0 + 1;
            bus.hold  = (rn == hold_at) || (rn == hold_at + 1);
            bus.start = (rn == st_a) || (rn == st_b);
            reset     = (rn == rst_at);
            if (rn == 1) check_eq("busy_first", int'(bus.busy), 1);
            if (rst_at > 0 && rn == rst_at + 1) begin
                #1;
                check_eq("rst_busy", int'(bus.busy), 0);
                check_eq("rst_rd_en", int'(bus.rd_en), 0);
                check_eq("rst_wb_en", int'(bus.wb_en), 0);
            end
            tick();
        end
        bus.hold  = 1'b0;
        bus.start = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic check_run(input string tag, input bit use_hold, input int done_rel);
        int r;
        check_eq({tag, "_rd_count"}, rdq.size(), 12 + NSW);
        check_eq({tag, "_wb_count"}, wbq.size(), 12 + NSW);
`ifdef FFT_SEQ_BITREV_EN
        for (int j = 0; j < 2; j++) begin
            if (j < rdq.size()) begin
                check_eq($sformatf("%s_sw%0d_rel", tag, j), rdq[j].rel, sw_rel[j]);
                check_eq($sformatf("%s_sw%0d_a", tag, j), rdq[j].a, sw_a[j]);
                check_eq($sformatf("%s_sw%0d_b", tag, j), rdq[j].b, sw_b[j]);
                check_eq($sformatf("%s_sw%0d_bp", tag, j), rdq[j].bp, 1);
                check_eq($sformatf("%s_sw%0d_tw", tag, j), rdq[j].tw, 0);
            end
            if (j < wbq.size()) begin
                check_eq($sformatf("%s_swwb%0d_rel", tag, j), wbq[j].rel, sw_rel[j] + BF_LAT);
                check_eq($sformatf("%s_swwb%0d_a", tag, j), wbq[j].a, sw_b[j]);
                check_eq($sformatf("%s_swwb%0d_b", tag, j), wbq[j].b, sw_a[j]);
            end
        end
`endif
        for (int i = 0; i < 12; i++) begin
            r = use_hold ? rel_hold[i] : rel_nohold[i];
            if (i + NSW < rdq.size()) begin
                check_eq($sformatf("%s_rd%0d_rel", tag, i), rdq[i+NSW].rel, r + OFS);
                check_eq($sformatf("%s_rd%0d_a", tag, i), rdq[i+NSW].a, ea[i]);
                check_eq($sformatf("%s_rd%0d_b", tag, i), rdq[i+NSW].b, eb[i]);
                check_eq($sformatf("%s_rd%0d_tw", tag, i), rdq[i+NSW].tw, et[i]);
                check_eq($sformatf("%s_rd%0d_bp", tag, i), rdq[i+NSW].bp, 0);
                check_eq($sformatf("%s_rd%0d_stage", tag, i), rdq[i+NSW].st, i / 4);
            end
            if (i + NSW < wbq.size()) begin
                check_eq($sformatf("%s_wb%0d_rel", tag, i), wbq[i+NSW].rel, r + OFS + BF_LAT);
                check_eq($sformatf("%s_wb%0d_a", tag, i), wbq[i+NSW].a, ea[i]);
                check_eq($sformatf("%s_wb%0d_b", tag, i), wbq[i+NSW].b, eb[i]);
            end
        end
        check_eq({tag, "_done_count"}, doneq.size(), 1);
        check_eq({tag, "_done_rel"}, (doneq.size() > 0) ? doneq[0] : -1, done_rel);
        check_eq({tag, "_idle_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int late;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        repeat (3) tick();
        check_eq("reset_busy", int'(bus.busy), 0);
        check_eq("reset_done", int'(bus.done), 0);
        check_eq("reset_rd_en", int'(bus.rd_en), 0);
        check_eq("reset_wb_en", int'(bus.wb_en), 0);
        check_eq("reset_bypass", int'(bus.bypass), 0);
        check_eq("reset_stage", int'(bus.stage), 0);
        check_eq("reset_rd_a", int'(bus.rd_addr_a), 0);
        check_eq("reset_rd_b", int'(bus.rd_addr_b), 0);
        check_eq("reset_tw", int'(bus.tw_idx), 0);
        check_eq("reset_wb_a", int'(bus.wb_addr_a), 0);
        check_eq("reset_wb_b", int'(bus.wb_addr_b), 0);

        bus.start = 1'b1;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (3) tick();
        check_eq("start_with_reset_busy", int'(bus.busy), 0);
        check_eq("start_with_reset_rd", rdq.size(), 0);

        run(-10, -10, -10, -10, 45 + OFS);
        check_run("plain", 1'b0, 22 + OFS);

        run(9 + OFS, -10, -10, -10, 45 + OFS);
        check_run("hold", 1'b1, 24 + OFS);

        run(-10, 5, 22 + OFS, -10, 45 + OFS);
        check_run("restart", 1'b0, 22 + OFS);

        run(-10, -10, -10, 5, 40 + OFS);
        check_eq("rst_no_done", doneq.size(), 0);
        late = 0;
        foreach (rdq[j]) if (rdq[j].rel >= 6) late++;
        check_eq("rst_late_rd", late, 0);
        late = 0;
        foreach (wbq[j]) if (wbq[j].rel >= 6) late++;
        check_eq("rst_late_wb", late, 0);

        run(-10, -10, -10, -10, 45 + OFS);
        check_run("fresh", 1'b0, 22 + OFS);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
